// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are {2'b00, row, col}, numbered row-major from the top-left key.
package teclado_pkg;

  localparam int N_COLUMNAS = 4;
  localparam int N_FILAS    = 4;

  typedef enum logic [1:0] {
    ESCANEO,
    DEBOUNCE,
    PRESIONADA,
    LIBERACION
  } estado_t;

  localparam logic [5:0] TECLA_1   = 6'd0;
  localparam logic [5:0] TECLA_2   = 6'd1;
  localparam logic [5:0] TECLA_3   = 6'd2;
  localparam logic [5:0] TECLA_A   = 6'd3;
  localparam logic [5:0] TECLA_4   = 6'd4;
  localparam logic [5:0] TECLA_5   = 6'd5;
  localparam logic [5:0] TECLA_6   = 6'd6;
  localparam logic [5:0] TECLA_B   = 6'd7;
  localparam logic [5:0] TECLA_7   = 6'd8;
  localparam logic [5:0] TECLA_8   = 6'd9;
  localparam logic [5:0] TECLA_9   = 6'd10;
  localparam logic [5:0] TECLA_C   = 6'd11;
  localparam logic [5:0] TECLA_AST = 6'd12;
  localparam logic [5:0] TECLA_0   = 6'd13;
  localparam logic [5:0] TECLA_NUM = 6'd14;
  localparam logic [5:0] TECLA_D   = 6'd15;

  // Lowest-numbered low row wins when several keys share a column.
  function automatic logic [1:0] fila_prioritaria(input logic [N_FILAS-1:0] f);
    if (!f[0])      return 2'd0;
    else if (!f[1]) return 2'd1;
    else if (!f[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/escaneo_teclado_sincronizador.sv
// Generic N-bit two-flop synchronizer for asynchronous level inputs.
// Resets to all ones so idle (pulled-up) lines read as inactive.
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same edge;
      // blocking here would collapse the chain into a single stage.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/escaneo_teclado.sv
// 4x4 keypad scanner: rotates one active-low column, debounces press and
// release, and emits the raw key code with a one-cycle key_detect strobe.
module escaneo_teclado
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_FILAS-1:0]    filas,
  output logic [N_COLUMNAS-1:0] columnas,
  output logic [5:0]            input_teclado,
  output logic                  key_detect
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_ULT = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_ULT = DEB_W'(DEBOUNCE_CYCLES - 1);

  estado_t            state, state_next;
  logic [DIV_W-1:0]   div, div_next;
  logic [DEB_W-1:0]   deb, deb_next;
  logic [1:0]         col, col_next;
  logic [1:0]         col_l, col_l_next;
  logic [1:0]         row_l, row_l_next;
  logic [5:0]         codigo_next;
  logic               pulso_next;
  logic [N_FILAS-1:0] filas_s;
  logic               filas_libres;

  sincronizador #(.WIDTH(N_FILAS)) u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (filas),
    .q     (filas_s)
  );

  assign filas_libres = (filas_s == '1);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ESCANEO;
      div           <= '0;
      deb           <= '0;
      col           <= '0;
      col_l         <= '0;
      row_l         <= '0;
      input_teclado <= '0;
      key_detect    <= 1'b0;
    end else begin
      state         <= state_next;
      div           <= div_next;
      deb           <= deb_next;
      col           <= col_next;
      col_l         <= col_l_next;
      row_l         <= row_l_next;
      input_teclado <= codigo_next;
      key_detect    <= pulso_next;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_next  = state;
    div_next    = div;
    deb_next    = deb;
    col_next    = col;
    col_l_next  = col_l;
    row_l_next  = row_l;
    codigo_next = input_teclado;
    pulso_next  = 1'b0;

    case (state)
      ESCANEO: begin
        // Only the last divider cycle samples; earlier cycles let rows settle.
        if (div == DIV_ULT) begin
          if (!filas_libres) begin
            col_l_next = col;
            row_l_next = fila_prioritaria(filas_s);
            deb_next   = '0;
            state_next = DEBOUNCE;
          end else begin
            col_next = col + 2'd1;
            div_next = '0;
          end
        end else begin
          div_next = div + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (filas_s[row_l]) begin
          state_next = ESCANEO;
          col_next   = col_l + 2'd1;
          div_next   = '0;
        end else if (deb == DEB_ULT) begin
          codigo_next = {2'b00, row_l, col_l};
          pulso_next  = 1'b1;
          state_next  = PRESIONADA;
        end else begin
          deb_next = deb + DEB_W'(1);
        end
      end

      PRESIONADA: begin
        if (filas_libres) begin
          deb_next   = '0;
          state_next = LIBERACION;
        end
      end

      LIBERACION: begin
        // Any row dropping low restarts the release window.
        if (!filas_libres) begin
          deb_next = '0;
        end else if (deb == DEB_ULT) begin
          state_next = ESCANEO;
          col_next   = col_l + 2'd1;
          div_next   = '0;
        end else begin
          deb_next = deb + DEB_W'(1);
        end
      end

      default: state_next = ESCANEO;
    endcase
  end

  always_comb begin
    columnas = ~(N_COLUMNAS'(1) << col);
  end

endmodule
